// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and types for the SRAM port arbiter
package mem_arb_pkg;

  localparam int NUM_MASTERS_DEF = 3;
  localparam int AW_DEF          = 32;
  localparam int DW_DEF          = 32;

  localparam int MST_SPI    = 0;
  localparam int MST_IFETCH = 1;
  localparam int MST_DATA   = 2;

  typedef logic [$clog2(NUM_MASTERS_DEF)-1:0] mst_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with a rotating priority pointer
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  elig,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  // Walk ptr, ptr+1, ... wrapping at N; the first eligible index wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && elig[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  // The winner drops to lowest priority on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (idx == IW'(N-1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port SRAM between SPI loader, ifetch and data port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   boot_lock_i,
  input  logic [NUM_MASTERS-1:0] m_req_i,
  input  logic [AW-1:0]          m_addr_i  [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0] m_we_i,
  input  logic [DW/8-1:0]        m_be_i    [NUM_MASTERS],
  input  logic [DW-1:0]          m_wdata_i [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0] m_gnt_o,
  output logic [NUM_MASTERS-1:0] m_rvalid_o,
  output logic [DW-1:0]          m_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AW-3:0]          mem_addr_o,
  output logic [DW/8-1:0]        mem_be_o,
  output logic [DW-1:0]          mem_wdata_o,
  input  logic [DW-1:0]          mem_rdata_i
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] lock_mask;
  logic [NUM_MASTERS-1:0] resp_q;
  logic [IW-1:0]          gnt_idx;
  logic                   addr_lsb_unused;

  // Boot lock leaves only the SPI loader eligible, effective in the same cycle.
  assign lock_mask = boot_lock_i ? (NUM_MASTERS'(1) << MST_SPI) : '1;
  assign elig      = m_req_i & lock_mask;

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr_arbiter (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .elig  (elig),
    .gnt   (m_gnt_o),
    .idx   (gnt_idx)
  );

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (|m_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = m_we_i[gnt_idx];
      mem_addr_o  = m_addr_i[gnt_idx][AW-1:2];
      mem_be_o    = m_be_i[gnt_idx];
      mem_wdata_o = m_wdata_i[gnt_idx];
    end
  end

  // Byte offsets are meaningless to a word-wide SRAM.
  always_comb begin
    addr_lsb_unused = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      addr_lsb_unused = addr_lsb_unused ^ (^m_addr_i[i][1:0]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else begin
      resp_q <= m_gnt_o;
    end
  end

  assign m_rvalid_o = resp_q;
  assign m_rdata_o  = mem_rdata_i;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single-port on-chip SRAM of `top_core` between its bus masters: the SPI device loader (master 0), core instruction fetch (master 1) and core data port (master 2). Masters use a req/gnt/rvalid handshake. The memory side is a one-cycle-latency SRAM. A boot-lock input gives the SPI loader exclusive access while the program image is written, before `fetch_enable_i` releases the core.

## Interface
Parameters:
- `NUM_MASTERS`, 3: number of requesters; index 0 is the SPI loader.
- `AW`, 32: byte address width.
- `DW`, 32: data width; byte-enable width is DW/8.

Ports:
- `clk_i` in 1: the single clock; all state changes on its rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `boot_lock_i` in 1: when 1, only master 0 may be granted.
- `m_req_i` in [NUM_MASTERS]: request per master.
- `m_addr_i` in [NUM_MASTERS][AW]: byte address.
- `m_we_i` in [NUM_MASTERS]: 1 = write.
- `m_be_i` in [NUM_MASTERS][DW/8]: byte enables.
- `m_wdata_i` in [NUM_MASTERS][DW]: write data.
- `m_gnt_o` out [NUM_MASTERS]: grant, at most one bit high.
- `m_rvalid_o` out [NUM_MASTERS]: response valid, one cycle after grant.
- `m_rdata_o` out DW: read data, broadcast to all masters.
- `mem_req_o` out 1: SRAM access strobe.
- `mem_we_o` out 1: SRAM write enable.
- `mem_addr_o` out AW-2: word address, equal to `m_addr_i[g][AW-1:2]`.
- `mem_be_o` out DW/8: SRAM byte enables.
- `mem_wdata_o` out DW: SRAM write data.
- `mem_rdata_i` in DW: SRAM read data, valid the cycle after `mem_req_o`.

## Operation
- **Eligible set.** `elig = m_req_i`. When `boot_lock_i`=1, `elig` is masked to bit 0 only.
- **Grant.**
  - Combinational from `elig` and the priority pointer `ptr`.
  - The winner is the first eligible index searching `ptr`, `ptr+1`, …, wrapping modulo NUM_MASTERS.
  - `m_gnt_o` is one-hot or zero.
- **Pointer.**
  - On any grant to index g, `ptr` ← (g+1) mod NUM_MASTERS at the next edge.
  - With no grant, `ptr` holds.
  - Result: a master that just won has the lowest priority next cycle.
- **Memory drive.**
  - `mem_req_o` = |`m_gnt_o`.
  - `mem_we_o`, `mem_addr_o`, `mem_be_o` and `mem_wdata_o` are muxed from the granted master.
  - With no grant, all memory outputs are 0.
- **Response tracking.**
  - A registered one-hot `resp_q` takes the value of `m_gnt_o` at every edge.
  - `m_rvalid_o` = `resp_q`.
  - Writes also receive an rvalid; their `m_rdata_o` content is don't-care.
- **Read data.** `m_rdata_o` = `mem_rdata_i` passthrough. Only the master whose rvalid is high may consume it.
- **Request hold rule.**
  - A master keeps req and its attributes stable until it sees gnt.
  - It may drop req only after gnt.
  - The arbiter never revokes a grant within a cycle.
- **Back-to-back.** A single requesting master with req held high is granted every cycle, so throughput is one access per cycle.
- **Boot lock.**
  - Asserting `boot_lock_i` masks masters 1..N-1 immediately, in the same cycle.
  - It does not cancel a response already in `resp_q`.

## Timing
- Reset values: `ptr`=0, `resp_q`=0. Consequently `m_rvalid_o`=0.
- Combinational outputs during reset:
  - `m_gnt_o` and the memory outputs follow the inputs combinationally even in reset; the bench drives all req=0 during reset.
  - `m_rdata_o` follows `mem_rdata_i`.
- Latency:
  - Grant is 0 cycles from req (same cycle).
  - rvalid and rdata arrive exactly 1 cycle after grant.
- Contention:
  - N simultaneously held requests are served in rotating order.
  - Worst-case wait is NUM_MASTERS-1 cycles.
- Reset mid-operation clears `resp_q`. A response pending at reset is dropped and its rvalid never appears.
- Pointer wrap: after index NUM_MASTERS-1 wins, `ptr` returns to 0.
- Simultaneous grant and pointer update: the grant uses the current `ptr`; the new value applies from the next cycle.

## Structure
- Package `mem_arb_pkg`:
  - `DW` and `AW` defaults.
  - `MST_SPI`=0, `MST_IFETCH`=1, `MST_DATA`=2.
  - `mst_idx_t` as `logic [$clog2(NUM_MASTERS)-1:0]`.
- Sub-module `rr_arbiter`:
  - Parameterized width.
  - Inputs: `elig`; outputs: one-hot gnt and encoded index.
  - Owns `ptr` with the same clock and reset.
- The top level holds the memory mux and `resp_q`.

## Test plan
- **Single read.** Master 1 requests read at 0x80 with SRAM word 0x00000013 → gnt1 the same cycle, `mem_addr_o`=0x20, `m_rvalid_o[1]`=1 and `m_rdata_o`=0x13 one cycle later.
- **Three-way contention.** All three masters hold req for 6 cycles from reset → grant order 0,1,2,0,1,2, with one rvalid per cycle trailing by one.
- **Boot lock.** With `boot_lock_i`=1 and masters 0 and 2 requesting → only master 0 is granted. SPI writes 0x00000fff at 0x80+4*31 → SRAM word 0x3F receives it. Master 2 is granted in the cycle `boot_lock_i` drops.
- **Write then read-back.** Master 0 writes 0xDEADBEEF with be=4'b0011 to 0x84 (word pre-set to 0x11223344), then master 2 reads 0x84 → rdata 0x1122BEEF.
- **Back-to-back.** Master 2 holds req for 4 cycles alone → 4 consecutive grants and 4 consecutive rvalids, with `ptr` staying at 0.
- **Reset mid-operation.** Grant master 1, then assert `rst_ni`=0 before the next edge → `m_rvalid_o`=0 after reset and `ptr`=0, so master 0 wins the first contended cycle.
